// File: rtl/sa_pkg.sv
// Shared types for the systolic-array output drain: element, row and matrix
// containers at the default array geometry, plus the per-bank occupancy state.
package sa_pkg;

  localparam int SA_D_W  = 8;
  localparam int SA_ROWS = 16;
  localparam int SA_COLS = 16;

  typedef logic signed [SA_D_W-1:0] sa_elem_t;
  typedef sa_elem_t                 sa_row_t [0:SA_COLS-1];
  typedef sa_row_t                  sa_mat_t [0:SA_ROWS-1];

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

endpackage

// File: rtl/sa_drain_bank.sv
// One result-matrix store: whole-matrix write, single-row read port and an
// occupancy flag. A write in the same cycle as a release leaves the bank FULL,
// because that is how a capture reuses a bank that is being freed.
module sa_drain_bank
  import sa_pkg::*;
#(
  parameter int D_W  = SA_D_W,
  parameter int SA_R = SA_ROWS,
  parameter int SA_C = SA_COLS,
  parameter int RW   = $clog2(SA_R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_n,
  input  logic           wr_en,
  input  logic           rel,
  input  logic [D_W-1:0] wr_data [0:SA_R-1][0:SA_C-1],
  input  logic [RW-1:0]  rd_row,
  output logic [D_W-1:0] rd_data [0:SA_C-1],
  output logic           full
);

  logic [D_W-1:0] mem [0:SA_R-1][0:SA_C-1];
  bank_state_e    state;

  // Matrix storage; contents are only meaningful while the flag is FULL.
  always_ff @(posedge clk) begin
    if (wr_en) mem <= wr_data;
  end

  // Occupancy flag: clear beats everything, then capture beats release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= BANK_FREE;
    else if (!clr_n) state <= BANK_FREE;
    else if (wr_en)  state <= BANK_FULL;
    else if (rel)    state <= BANK_FREE;
  end

  assign rd_data = mem[rd_row];
  assign full    = (state == BANK_FULL);

endmodule

// File: rtl/sa_out_drain.sv
// Ping-pong result drain: captures SA result matrices into two banks and
// streams them row by row over valid/ready. Captures that find no free bank
// are dropped and flagged.
// Build option: define SA_DRAIN_RELU_EN to clamp negative output elements to 0.
module sa_out_drain
  import sa_pkg::*;
#(
  parameter int D_W  = SA_D_W,
  parameter int SA_R = SA_ROWS,
  parameter int SA_C = SA_COLS
) (
  input  logic                    I_CLK,
  input  logic                    I_ASYN_RSTN,
  input  logic                    I_SYNC_RSTN,
  input  logic                    I_OUT_VLD,
  input  logic [D_W-1:0]          I_OUT [0:SA_R-1][0:SA_C-1],
  input  logic                    I_ROW_RDY,
  output logic                    O_ROW_VLD,
  output logic [D_W-1:0]          O_ROW_DATA [0:SA_C-1],
  output logic [$clog2(SA_R)-1:0] O_ROW_IDX,
  output logic                    O_ROW_LAST,
  output logic                    O_FULL,
  output logic                    O_DROP,
  output logic                    O_MAT_DONE
);

  localparam int RW = $clog2(SA_R);

  logic           wr_ptr, rd_ptr;
  logic [RW-1:0]  row_cnt;
  logic           drop_q, done_q;
  logic [1:0]     bank_full, bank_wr, bank_rel;
  logic [D_W-1:0] rd0 [0:SA_C-1];
  logic [D_W-1:0] rd1 [0:SA_C-1];
  logic [D_W-1:0] elem;
  logic           row_vld, at_last, xfer, last_xfer, wr_free, cap;

  assign row_vld   = rd_ptr ? bank_full[1] : bank_full[0];
  assign at_last   = (row_cnt == RW'(SA_R - 1));
  assign xfer      = row_vld && I_ROW_RDY;
  assign last_xfer = xfer && at_last;
  // Release is evaluated before capture so a full-full collision is not a drop.
  assign wr_free   = !bank_full[wr_ptr] || (last_xfer && (rd_ptr == wr_ptr));
  assign cap       = I_OUT_VLD && wr_free;
  assign bank_wr   = {cap && wr_ptr, cap && !wr_ptr};
  assign bank_rel  = {last_xfer && rd_ptr, last_xfer && !rd_ptr};

  sa_drain_bank #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .RW(RW)) u_bank0 (
    .clk    (I_CLK),
    .rst_n  (I_ASYN_RSTN),
    .clr_n  (I_SYNC_RSTN),
    .wr_en  (bank_wr[0]),
    .rel    (bank_rel[0]),
    .wr_data(I_OUT),
    .rd_row (row_cnt),
    .rd_data(rd0),
    .full   (bank_full[0])
  );

  sa_drain_bank #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .RW(RW)) u_bank1 (
    .clk    (I_CLK),
    .rst_n  (I_ASYN_RSTN),
    .clr_n  (I_SYNC_RSTN),
    .wr_en  (bank_wr[1]),
    .rel    (bank_rel[1]),
    .wr_data(I_OUT),
    .rd_row (row_cnt),
    .rd_data(rd1),
    .full   (bank_full[1])
  );

  // Pointers, row counter and the registered drop/done pulses.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_cnt <= '0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_cnt <= '0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      drop_q <= I_OUT_VLD && !wr_free;
      done_q <= last_xfer;
      if (cap)       wr_ptr <= ~wr_ptr;
      if (last_xfer) rd_ptr <= ~rd_ptr;
      if (xfer)      row_cnt <= at_last ? '0 : row_cnt + 1'b1;
    end
  end

  // Row output mux; forced to zero when idle so outputs read 0 out of reset.
  always_comb begin
    elem = '0;
    for (int c = 0; c < SA_C; c++) begin
      elem = rd_ptr ? rd1[c] : rd0[c];
      if (!row_vld) elem = '0;
`ifdef SA_DRAIN_RELU_EN
      if (elem[D_W-1]) elem = '0;
`endif
      O_ROW_DATA[c] = elem;
    end
  end

  assign O_ROW_VLD  = row_vld;
  assign O_ROW_IDX  = row_cnt;
  assign O_ROW_LAST = row_vld && at_last;
  assign O_FULL     = &bank_full;
  assign O_DROP     = drop_q;
  assign O_MAT_DONE = done_q;

endmodule
